// File: rtl/hwpe_ctrl_regfile_ff_mp_if.sv
// Bus bundle for the multi-port flip-flop register file.
// The master side drives the read/write requests. The slave side is the register file itself.
interface hwpe_ctrl_regfile_ff_mp_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int N_RPORTS   = 2,
    parameter int N_WPORTS   = 2
) ();
    localparam int NUM_WORDS = 2**ADDR_WIDTH;
    localparam int NUM_BYTE  = DATA_WIDTH/8;

    logic [N_RPORTS-1:0]                          rd_en;
    logic [N_RPORTS-1:0][ADDR_WIDTH-1:0]          rd_addr;
    logic [N_RPORTS-1:0][DATA_WIDTH-1:0]          rd_data;
    logic [N_RPORTS-1:0]                          rd_valid;
    logic [N_WPORTS-1:0]                          wr_en;
    logic [N_WPORTS-1:0][ADDR_WIDTH-1:0]          wr_addr;
    logic [N_WPORTS-1:0][NUM_BYTE-1:0][7:0]       wr_data;
    logic [N_WPORTS-1:0][NUM_BYTE-1:0]            wr_be;
    logic                                         wr_collision;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]         mem_content;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_be,
        input  rd_data, rd_valid, wr_collision, mem_content
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_be,
        output rd_data, rd_valid, wr_collision, mem_content
    );
endinterface

// File: rtl/hwpe_ctrl_regfile_ff_mp.sv
// Multi-port register file built from byte-wide flip-flops.
// It provides registered-address reads, per-byte write priority, and an optional write bypass.
module hwpe_ctrl_regfile_ff_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int N_RPORTS   = 2,
    parameter int N_WPORTS   = 2,
    parameter int BYPASS     = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    hwpe_ctrl_regfile_ff_mp_if.slave  bus
);
    localparam int NUM_WORDS = 2**ADDR_WIDTH;
    localparam int NUM_BYTE  = DATA_WIDTH/8;

    logic [NUM_WORDS-1:0][NUM_BYTE-1:0][7:0] w_mem;
    logic [NUM_WORDS-1:0][NUM_BYTE-1:0][7:0] w_wdata;
    logic [NUM_WORDS-1:0][NUM_BYTE-1:0]      w_we;
    logic [NUM_WORDS*NUM_BYTE-1:0]           w_conflict;

    logic [N_RPORTS-1:0][ADDR_WIDTH-1:0]     r_raddr;
    logic [N_RPORTS-1:0]                     r_rvalid;
    logic                                    r_collision;
    logic [N_RPORTS-1:0][NUM_BYTE-1:0][7:0]  w_rdata;

    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
        for (genvar b = 0; b < NUM_BYTE; b++) begin : g_byte
            logic [N_WPORTS-1:0] w_hit;
            logic [7:0]          w_bdata;
            logic [7:0]          r_byte;

            for (genvar p = 0; p < N_WPORTS; p++) begin : g_port
                assign w_hit[p] = bus.wr_en[p]
                                  && (bus.wr_addr[p] == ADDR_WIDTH'(w))
                                  && bus.wr_be[p][b];
            end

            // Scan from the highest port downwards so the lowest-indexed hit is the one that remains.
            always_comb begin
                w_bdata = '0;
                for (int p = N_WPORTS-1; p >= 0; p--) begin
                    if (w_hit[p]) begin
                        w_bdata = bus.wr_data[p][b];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_byte <= '0;
                end else if (clear) begin
                    r_byte <= '0;
                end else if (|w_hit) begin
                    r_byte <= w_bdata;
                end
            end

            assign w_we[w][b]    = |w_hit;
            assign w_wdata[w][b] = w_bdata;
            assign w_mem[w][b]   = r_byte;
            // More than one bit set in the hit vector means two or more ports hit the same byte.
            assign w_conflict[w*NUM_BYTE+b] = |(w_hit & (w_hit - N_WPORTS'(1)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raddr     <= '0;
            r_rvalid    <= '0;
            r_collision <= 1'b0;
        end else if (clear) begin
            r_raddr     <= '0;
            r_rvalid    <= '0;
            r_collision <= 1'b0;
        end else begin
            r_rvalid    <= bus.rd_en;
            r_collision <= |w_conflict;
            for (int r = 0; r < N_RPORTS; r++) begin
                if (bus.rd_en[r]) begin
                    r_raddr[r] <= bus.rd_addr[r];
                end
            end
        end
    end

    // Read data follows the registered address continuously. Bypass swaps in the bytes being written this cycle.
    always_comb begin
        w_rdata = '0;
        for (int r = 0; r < N_RPORTS; r++) begin
            for (int b = 0; b < NUM_BYTE; b++) begin
                if ((BYPASS != 0) && w_we[r_raddr[r]][b]) begin
                    w_rdata[r][b] = w_wdata[r_raddr[r]][b];
                end else begin
                    w_rdata[r][b] = w_mem[r_raddr[r]][b];
                end
            end
        end
    end

    assign bus.rd_data      = w_rdata;
    assign bus.rd_valid     = r_rvalid;
    assign bus.wr_collision = r_collision;
    assign bus.mem_content  = w_mem;

endmodule

// File: tb/tb_hwpe_ctrl_regfile_ff_mp.sv
// Directed bench for hwpe_ctrl_regfile_ff_mp.
// It runs two instances side by side, one with BYPASS=0 and one with BYPASS=1, on shared stimulus.
module tb_hwpe_ctrl_regfile_ff_mp;
    logic              clk;
    logic              rst_n;
    logic              clear;
    logic [1:0]        rd_en;
    logic [1:0][4:0]   rd_addr;
    logic [1:0]        wr_en;
    logic [1:0][4:0]   wr_addr;
    logic [1:0][31:0]  wr_data;
    logic [1:0][3:0]   wr_be;

    int n_cmp;
    int n_err;

    hwpe_ctrl_regfile_ff_mp_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .N_RPORTS(2), .N_WPORTS(2)) bus0 ();
    hwpe_ctrl_regfile_ff_mp_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .N_RPORTS(2), .N_WPORTS(2)) bus1 ();

    assign bus0.rd_en   = rd_en;
    assign bus0.rd_addr = rd_addr;
    assign bus0.wr_en   = wr_en;
    assign bus0.wr_addr = wr_addr;
    assign bus0.wr_data = wr_data;
    assign bus0.wr_be   = wr_be;
    assign bus1.rd_en   = rd_en;
    assign bus1.rd_addr = rd_addr;
    assign bus1.wr_en   = wr_en;
    assign bus1.wr_addr = wr_addr;
    assign bus1.wr_data = wr_data;
    assign bus1.wr_be   = wr_be;

    hwpe_ctrl_regfile_ff_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .N_RPORTS(2), .N_WPORTS(2), .BYPASS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus0)
    );
    hwpe_ctrl_regfile_ff_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .N_RPORTS(2), .N_WPORTS(2), .BYPASS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear   = 1'b0;
        rd_en   = '0;
        rd_addr = '0;
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        wr_be   = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #12;
        n_cmp++; if (bus0.mem_content !== '0) begin n_err++; $display("FAIL reset_mem0: got nonzero expected 0"); end
        n_cmp++; if (bus1.mem_content !== '0) begin n_err++; $display("FAIL reset_mem1: got nonzero expected 0"); end
        n_cmp++; if (bus0.rd_valid !== 2'b00) begin n_err++; $display("FAIL reset_valid: got %b expected 00", bus0.rd_valid); end
        n_cmp++; if (bus0.wr_collision !== 1'b0) begin n_err++; $display("FAIL reset_coll: got %b expected 0", bus0.wr_collision); end
        n_cmp++; if (bus0.rd_data[0] !== 32'h0 || bus0.rd_data[1] !== 32'h0) begin
            n_err++; $display("FAIL reset_rdata: got %h %h expected 0 0", bus0.rd_data[0], bus0.rd_data[1]);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        idle();
        wr_en[0] = 1'b1; wr_addr[0] = 5'd3; wr_data[0] = 32'hDEADBEEF; wr_be[0] = 4'hF;
        tick();
        idle();
        rd_en[1] = 1'b1; rd_addr[1] = 5'd3;
        tick();
        n_cmp++; if (bus0.rd_valid !== 2'b10) begin n_err++; $display("FAIL basic_valid: got %b expected 10", bus0.rd_valid); end
        n_cmp++; if (bus0.rd_data[1] !== 32'hDEADBEEF) begin n_err++; $display("FAIL basic_rdata: got %h expected deadbeef", bus0.rd_data[1]); end
        n_cmp++; if (bus0.mem_content[3] !== 32'hDEADBEEF) begin n_err++; $display("FAIL basic_mem: got %h expected deadbeef", bus0.mem_content[3]); end
        n_cmp++; if (bus0.wr_collision !== 1'b0) begin n_err++; $display("FAIL basic_coll: got %b expected 0", bus0.wr_collision); end
        idle();
    endtask

    task automatic test_merge();
        idle();
        wr_en = 2'b11;
        wr_addr[0] = 5'd5; wr_data[0] = 32'h11111111; wr_be[0] = 4'h3;
        wr_addr[1] = 5'd5; wr_data[1] = 32'h22222222; wr_be[1] = 4'h6;
        tick();
        n_cmp++; if (bus0.mem_content[5] !== 32'h00221111) begin n_err++; $display("FAIL merge_word: got %h expected 00221111", bus0.mem_content[5]); end
        n_cmp++; if (bus0.wr_collision !== 1'b1) begin n_err++; $display("FAIL merge_coll_hi: got %b expected 1", bus0.wr_collision); end
        // Disjoint bytes of one word and the same byte of different words must not report a collision.
        wr_addr[0] = 5'd6; wr_data[0] = 32'h000000AA; wr_be[0] = 4'h1;
        wr_addr[1] = 5'd6; wr_data[1] = 32'h0000BB00; wr_be[1] = 4'h2;
        tick();
        n_cmp++; if (bus0.wr_collision !== 1'b0) begin n_err++; $display("FAIL merge_coll_pulse: got %b expected 0", bus0.wr_collision); end
        n_cmp++; if (bus0.mem_content[6] !== 32'h0000BBAA) begin n_err++; $display("FAIL merge_disjoint: got %h expected 0000bbaa", bus0.mem_content[6]); end
        wr_addr[0] = 5'd10; wr_data[0] = 32'h01020304; wr_be[0] = 4'hF;
        wr_addr[1] = 5'd11; wr_data[1] = 32'h05060708; wr_be[1] = 4'hF;
        tick();
        n_cmp++; if (bus0.wr_collision !== 1'b0) begin n_err++; $display("FAIL merge_diff_addr_coll: got %b expected 0", bus0.wr_collision); end
        n_cmp++; if (bus0.mem_content[11] !== 32'h05060708) begin n_err++; $display("FAIL merge_port1_word: got %h expected 05060708", bus0.mem_content[11]); end
        idle();
    endtask

    task automatic test_bypass();
        idle();
        wr_en[0] = 1'b1; wr_addr[0] = 5'd7; wr_data[0] = 32'h12345678; wr_be[0] = 4'hF;
        tick();
        idle();
        rd_en[0] = 1'b1; rd_addr[0] = 5'd7;
        tick();
        idle();
        wr_en[0] = 1'b1; wr_addr[0] = 5'd7; wr_data[0] = 32'hA5A5A5A5; wr_be[0] = 4'hF;
        #1;
        n_cmp++; if (bus0.rd_data[0] !== 32'h12345678) begin n_err++; $display("FAIL bypass0_old: got %h expected 12345678", bus0.rd_data[0]); end
        n_cmp++; if (bus1.rd_data[0] !== 32'hA5A5A5A5) begin n_err++; $display("FAIL bypass1_new: got %h expected a5a5a5a5", bus1.rd_data[0]); end
        tick();
        wr_data[0] = 32'h000000FF; wr_be[0] = 4'h1;
        #1;
        n_cmp++; if (bus0.rd_data[0] !== 32'hA5A5A5A5) begin n_err++; $display("FAIL bypass0_commit: got %h expected a5a5a5a5", bus0.rd_data[0]); end
        n_cmp++; if (bus1.rd_data[0] !== 32'hA5A5A5FF) begin n_err++; $display("FAIL bypass1_byte: got %h expected a5a5a5ff", bus1.rd_data[0]); end
        tick();
        idle();
        n_cmp++; if (bus0.rd_data[0] !== 32'hA5A5A5FF) begin n_err++; $display("FAIL bypass0_after: got %h expected a5a5a5ff", bus0.rd_data[0]); end
    endtask

    task automatic test_hold();
        idle();
        wr_en[0] = 1'b1; wr_addr[0] = 5'd9; wr_data[0] = 32'h0BADCAFE; wr_be[0] = 4'hF;
        tick();
        idle();
        rd_en = 2'b11; rd_addr[0] = 5'd9; rd_addr[1] = 5'd3;
        tick();
        n_cmp++; if (bus0.rd_valid !== 2'b11) begin n_err++; $display("FAIL hold_valid_hi: got %b expected 11", bus0.rd_valid); end
        n_cmp++; if (bus0.rd_data[0] !== 32'h0BADCAFE || bus0.rd_data[1] !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL hold_dual_read: got %h %h expected 0badcafe deadbeef", bus0.rd_data[0], bus0.rd_data[1]);
        end
        rd_en = 2'b00; rd_addr[0] = 5'd1; rd_addr[1] = 5'd1;
        tick();
        n_cmp++; if (bus0.rd_valid !== 2'b00) begin n_err++; $display("FAIL hold_valid_lo: got %b expected 00", bus0.rd_valid); end
        n_cmp++; if (bus0.rd_data[0] !== 32'h0BADCAFE) begin n_err++; $display("FAIL hold_addr: got %h expected 0badcafe", bus0.rd_data[0]); end
        wr_en[1] = 1'b1; wr_addr[1] = 5'd9; wr_data[1] = 32'h13579BDF; wr_be[1] = 4'hF;
        tick();
        idle();
        n_cmp++; if (bus0.rd_data[0] !== 32'h13579BDF) begin n_err++; $display("FAIL hold_track: got %h expected 13579bdf", bus0.rd_data[0]); end
    endtask

    task automatic test_clear();
        idle();
        rd_en = 2'b11; rd_addr[0] = 5'd9; rd_addr[1] = 5'd3;
        tick();
        clear = 1'b1;
        wr_en = 2'b11;
        wr_addr[0] = 5'd2; wr_data[0] = 32'hCAFEF00D; wr_be[0] = 4'hF;
        wr_addr[1] = 5'd2; wr_data[1] = 32'h87654321; wr_be[1] = 4'hF;
        tick();
        idle();
        n_cmp++; if (bus0.mem_content !== '0) begin n_err++; $display("FAIL clear_mem: got nonzero (word2 %h) expected 0", bus0.mem_content[2]); end
        n_cmp++; if (bus0.rd_valid !== 2'b00) begin n_err++; $display("FAIL clear_valid: got %b expected 00", bus0.rd_valid); end
        n_cmp++; if (bus0.wr_collision !== 1'b0) begin n_err++; $display("FAIL clear_coll: got %b expected 0", bus0.wr_collision); end
        n_cmp++; if (bus0.rd_data[0] !== 32'h0) begin n_err++; $display("FAIL clear_rdata: got %h expected 0", bus0.rd_data[0]); end
    endtask

    task automatic test_async_reset();
        idle();
        wr_en[0] = 1'b1; wr_addr[0] = 5'd4; wr_data[0] = 32'h55AA55AA; wr_be[0] = 4'hF;
        tick();
        idle();
        rd_en[0] = 1'b1; rd_addr[0] = 5'd4;
        tick();
        idle();
        n_cmp++; if (bus0.rd_valid !== 2'b01 || bus0.mem_content[4] !== 32'h55AA55AA) begin
            n_err++; $display("FAIL areset_pre: got %b %h expected 01 55aa55aa", bus0.rd_valid, bus0.mem_content[4]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus0.mem_content !== '0) begin n_err++; $display("FAIL areset_mem: got nonzero (word4 %h) expected 0", bus0.mem_content[4]); end
        n_cmp++; if (bus0.rd_valid !== 2'b00) begin n_err++; $display("FAIL areset_valid: got %b expected 00", bus0.rd_valid); end
        rst_n = 1'b1;
        wr_en[0] = 1'b1; wr_addr[0] = 5'd8; wr_data[0] = 32'h0F0F0F0F; wr_be[0] = 4'hF;
        rd_en[1] = 1'b1; rd_addr[1] = 5'd8;
        tick();
        idle();
        n_cmp++; if (bus0.mem_content[8] !== 32'h0F0F0F0F) begin n_err++; $display("FAIL areset_first_edge: got %h expected 0f0f0f0f", bus0.mem_content[8]); end
        n_cmp++; if (bus0.rd_valid !== 2'b10 || bus0.rd_data[1] !== 32'h0F0F0F0F) begin
            n_err++; $display("FAIL areset_first_read: got %b %h expected 10 0f0f0f0f", bus0.rd_valid, bus0.rd_data[1]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_merge();
        test_bypass();
        test_hold();
        test_clear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
